// File: rtl/i2s_tx.sv
// ----------------------------------------------------------------------------
// i2s_tx
//
// Registered-output Philips I2S transmitter. Each accepted mono sample is
// duplicated onto the left and right channels of one frame. A frame is
// 2*RESOLUTION bit-clock slots long, and the data is sent MSB first with the
// standard one-slot delay after every lrclk transition.
//
// Parameters
//   RESOLUTION : sample width in bits, which is also the slot count per channel
//   CLK_DIV    : clk cycles per bclk half-period (must be 1 or more)
//
// Ports
//   clk        : system clock; all state changes on its rising edge
//   rst        : asynchronous, active-high reset
//   enable     : run control; low parks the serial outputs in the idle state
//   data_in    : mono sample from the upstream stage
//   data_valid : data_in is valid this cycle
//   data_ready : the one-entry holding register can take a sample
//   bclk       : serial bit clock
//   lrclk      : word select (0 = left, 1 = right)
//   sdata      : serial data
//   underrun   : one-clk pulse when a frame starts with no sample held
// ----------------------------------------------------------------------------
module i2s_tx #(
    parameter int RESOLUTION = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [RESOLUTION-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun
);

    localparam int SLOTS  = 2 * RESOLUTION;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [SLOT_W-1:0] LAST_SLOT   = SLOT_W'(SLOTS - 1);
    localparam logic [SLOT_W-1:0] RIGHT_FIRST = SLOT_W'(RESOLUTION);
    // SLOTS reduced modulo 2**SLOT_W; subtracting a slot number from it in
    // SLOT_W-bit arithmetic yields SLOTS - slot for every slot in 1..SLOTS-1.
    localparam logic [SLOT_W-1:0] SLOTS_MOD   = SLOT_W'(SLOTS);
    localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]      div_reg,       div_next;
    logic                  bclk_reg,      bclk_next;
    logic [SLOT_W-1:0]     slot_reg,      slot_next;
    logic                  lrclk_reg,     lrclk_next;
    logic                  sdata_reg,     sdata_next;
    logic [SLOTS-1:0]      frame_reg,     frame_next;
    logic [RESOLUTION-1:0] hold_reg,      hold_next;
    logic                  hold_full_reg, hold_full_next;
    logic                  underrun_reg,  underrun_next;

    logic                  accept;
    logic [SLOTS-1:0]      dup_word;
    logic [SLOT_W-1:0]     slot_inc;
    logic [SLOT_W-1:0]     bit_idx;

    assign data_ready = enable && !hold_full_reg;
    assign accept     = data_valid && data_ready;

    // Frame word is the held sample copied into both channel halves.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dup
            assign dup_word[gi*RESOLUTION +: RESOLUTION] = hold_reg;
        end
    endgenerate

    // Slot number entered on a bclk fall, and the frame bit it carries.
    assign slot_inc = (slot_reg == LAST_SLOT) ? '0 : slot_reg + 1'b1;
    assign bit_idx  = SLOTS_MOD - slot_inc;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        div_next       = div_reg;
        bclk_next      = bclk_reg;
        slot_next      = slot_reg;
        lrclk_next     = lrclk_reg;
        sdata_next     = sdata_reg;
        frame_next     = frame_reg;
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        underrun_next  = 1'b0;

        // Accept is only possible while the holding register is empty, so it
        // never collides with the frame load emptying it.
        if (accept) begin
            hold_next      = data_in;
            hold_full_next = 1'b1;
        end

        if (!enable) begin
            // Park exactly as after reset so re-enabling starts a fresh frame.
            // Clearing the frame word also clears the bit replayed in slot 0.
            div_next   = '0;
            bclk_next  = 1'b0;
            sdata_next = 1'b0;
            lrclk_next = 1'b1;
            slot_next  = LAST_SLOT;
            frame_next = '0;
        end else if (div_reg == DIV_LAST) begin
            div_next  = '0;
            bclk_next = !bclk_reg;
            if (bclk_reg) begin
                // Falling bclk: advance slot, word select and serial data.
                slot_next  = slot_inc;
                lrclk_next = (slot_inc >= RIGHT_FIRST);
                if (slot_inc == '0) begin
                    // Slot 0 still carries the LSB of the outgoing word.
                    sdata_next = frame_reg[0];
                    if (hold_full_reg) begin
                        frame_next     = dup_word;
                        hold_full_next = 1'b0;
                    end else begin
                        // A sample accepted on this same edge waits for the
                        // next frame; this one goes out silent.
                        frame_next    = '0;
                        underrun_next = 1'b1;
                    end
                end else begin
                    sdata_next = frame_reg[bit_idx];
                end
            end
        end else begin
            div_next = div_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg       <= '0;
            bclk_reg      <= 1'b0;
            slot_reg      <= LAST_SLOT;
            lrclk_reg     <= 1'b1;
            sdata_reg     <= 1'b0;
            frame_reg     <= '0;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            underrun_reg  <= 1'b0;
        end else begin
            div_reg       <= div_next;
            bclk_reg      <= bclk_next;
            slot_reg      <= slot_next;
            lrclk_reg     <= lrclk_next;
            sdata_reg     <= sdata_next;
            frame_reg     <= frame_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            underrun_reg  <= underrun_next;
        end
    end

    assign bclk     = bclk_reg;
    assign lrclk    = lrclk_reg;
    assign sdata    = sdata_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tx.sv
// ----------------------------------------------------------------------------
// tb_i2s_tx
//
// Directed bench for i2s_tx with RESOLUTION=32, CLK_DIV=4. A table of frames
// (sample offered beforehand, expected frame word, expected underrun) is played
// back-to-back after reset; hand-written sequences then cover back-pressure,
// accept on the load edge, disable mid-frame and asynchronous reset mid-frame.
// Outputs are sampled on the falling clk edge.
// ----------------------------------------------------------------------------
module tb_i2s_tx;

    localparam int RES = 32;
    localparam int DIV = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [RES-1:0] data_in;
    logic           data_valid;
    logic           data_ready;
    logic           bclk;
    logic           lrclk;
    logic           sdata;
    logic           underrun;

    always #5 clk = ~clk;

    i2s_tx #(
        .RESOLUTION (RES),
        .CLK_DIV    (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .bclk       (bclk),
        .lrclk      (lrclk),
        .sdata      (sdata),
        .underrun   (underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // bclk as it was before the latest rising edge; a fall is bclk_d && !bclk.
    logic bclk_d;
    always @(posedge clk or posedge rst) begin
        if (rst) bclk_d <= 1'b0;
        else     bclk_d <= bclk;
    end

    typedef struct packed {
        logic           present;
        logic [RES-1:0] data;
        logic           exp_ur;
        logic [RES-1:0] exp_word;
        logic           slot0;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        data_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Offer one sample and hold it until data_ready takes it.
    task automatic present(input logic [RES-1:0] d);
        bit r;
        int g;
        g = 0;
        @(negedge clk);
        data_in    = d;
        data_valid = 1'b1;
        do begin
            r = data_ready;
            @(posedge clk);
            g++;
        end while (!r && g < 100);
        chk("present_accept", r, 1);
        @(negedge clk);
        data_valid = 1'b0;
        $display("accept %h", d);
    endtask

    task automatic wait_falls(input int n, output bit ok);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        ok  = 1'b1;
        while (cnt < n) begin
            @(negedge clk);
            cyc++;
            if (bclk_d && !bclk) cnt++;
            if (cyc > n * 2 * DIV + 40) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    // Record 64 slots starting at the next bclk fall (slot 0 of a frame).
    task automatic capture(output logic [63:0] bits, output logic [63:0] lr,
                           output int ur_cnt, output int rdy_pre, output bit rdy_first,
                           output int first_at, output int rise_at, output bit ok);
        int cyc;
        int nfall;
        cyc = 0; nfall = 0;
        bits = '0; lr = '0;
        ur_cnt = 0; rdy_pre = 0; rdy_first = 1'b0;
        first_at = -1; rise_at = -1; ok = 1'b1;
        while (nfall < 64) begin
            @(negedge clk);
            cyc++;
            if (underrun) ur_cnt++;
            if (bclk && rise_at < 0) rise_at = cyc;
            if (bclk_d && !bclk) begin
                if (nfall == 0) begin
                    first_at  = cyc;
                    rdy_first = data_ready;
                end
                bits[nfall] = sdata;
                lr[nfall]   = lrclk;
                nfall++;
            end else if (nfall == 0 && data_ready) begin
                rdy_pre++;
            end
            if (cyc > 64 * 2 * DIV + 40) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    // Capture one frame and compare it against the expected sample word.
    task automatic check_frame(input string name, input logic [RES-1:0] w,
                               input logic exp_ur, input logic slot0,
                               output bit rdy_first, output int rdy_pre,
                               output int first_at, output int rise_at);
        logic [63:0] bits, lr, exp_bits, w64;
        logic [5:0]  idx;
        int          ur_cnt;
        bit          ok;
        capture(bits, lr, ur_cnt, rdy_pre, rdy_first, first_at, rise_at, ok);
        chk({name, "_done"}, ok, 1);
        w64 = {w, w};
        exp_bits = '0;
        exp_bits[0] = slot0;
        for (int s = 1; s < 64; s++) begin
            idx = 6'(64 - s);
            exp_bits[s] = w64[idx];
        end
        chk({name, "_sdata"}, bits, exp_bits);
        chk({name, "_lrclk"}, lr, 64'hFFFF_FFFF_0000_0000);
        chk({name, "_underrun"}, ur_cnt, exp_ur ? 1 : 0);
        $display("frame %s: sdata=%h underruns=%0d", name, bits, ur_cnt);
    endtask

    initial begin
        bit rf;
        bit ok;
        int rp, fa, ra;

        //          present data          ur    word          slot0
        tbl[0] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        tbl[1] = '{1'b1, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0};
        tbl[2] = '{1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1};
        tbl[3] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0};
        tbl[4] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};

        rst = 1'b1; enable = 1'b0; data_valid = 1'b0; data_in = '0;

        // Reset state; data_ready tracks enable even while in reset.
        repeat (2) @(negedge clk);
        chk("rst_bclk", bclk, 0);
        chk("rst_lrclk", lrclk, 1);
        chk("rst_sdata", sdata, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_ready_dis", data_ready, 0);
        enable = 1'b1;
        #1;
        chk("rst_ready_en", data_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back frames from the table.
        for (int k = 0; k < 6; k++) begin
            if (tbl[k].present) present(tbl[k].data);
            check_frame($sformatf("tbl%0d", k), tbl[k].exp_word, tbl[k].exp_ur,
                        tbl[k].slot0, rf, rp, fa, ra);
            chk($sformatf("tbl%0d_ready_after_load", k), rf, 1);
            if (tbl[k].present) chk($sformatf("tbl%0d_ready_while_full", k), rp, 0);
            if (k == 0) begin
                chk("first_rise_edge", ra, 4);
                chk("first_fall_edge", fa, 8);
            end
        end

        // Back-pressure: second sample waits for the load; hold is never overwritten.
        do_reset();
        present(32'h1234_5678);
        data_in = 32'hFFFF_FFFF;
        data_valid = 1'b1;
        fork
            check_frame("bp", 32'h1234_5678, 1'b0, 1'b0, rf, rp, fa, ra);
            begin
                repeat (30) @(negedge clk);
                data_in = 32'h0BAD_0BAD;
            end
        join
        data_valid = 1'b0;
        chk("bp_ready_while_full", rp, 0);
        chk("bp_ready_after_load", rf, 1);
        check_frame("bp_next", 32'hFFFF_FFFF, 1'b0, 1'b0, rf, rp, fa, ra);

        // Sample offered exactly on the first load edge.
        do_reset();
        repeat (7) @(posedge clk);
        @(negedge clk);
        data_in = 32'hA5A5_A5A5;
        data_valid = 1'b1;
        fork
            check_frame("simul_load", 32'h0, 1'b1, 1'b0, rf, rp, fa, ra);
            begin
                @(posedge clk);
                @(negedge clk);
                data_valid = 1'b0;
            end
        join
        chk("simul_ready_after_load", rf, 0);
        check_frame("simul_next", 32'hA5A5_A5A5, 1'b0, 1'b0, rf, rp, fa, ra);

        // Disable mid-frame at slot 20, re-enable 10 clk later.
        do_reset();
        present(32'h0000_1001);
        wait_falls(1, ok);
        chk("dis_wait0", ok, 1);
        present(32'h3C3C_C3C3);
        wait_falls(20, ok);
        chk("dis_wait20", ok, 1);
        repeat (5) @(negedge clk);
        chk("dis_pre_bclk", bclk, 1);
        chk("dis_pre_sdata", sdata, 1);
        chk("dis_pre_lrclk", lrclk, 0);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_bclk", bclk, 0);
        chk("dis_sdata", sdata, 0);
        chk("dis_lrclk", lrclk, 1);
        chk("dis_ready", data_ready, 0);
        chk("dis_underrun", underrun, 0);
        repeat (9) @(negedge clk);
        enable = 1'b1;
        check_frame("reenable", 32'h3C3C_C3C3, 1'b0, 1'b0, rf, rp, fa, ra);
        chk("reenable_rise_edge", ra, 4);
        chk("reenable_fall_edge", fa, 8);

        // Asynchronous reset in the middle of slot 40.
        do_reset();
        present(32'hFFFF_FFFF);
        wait_falls(1, ok);
        chk("arst_wait0", ok, 1);
        present(32'h5A5A_5A5A);
        wait_falls(40, ok);
        chk("arst_wait40", ok, 1);
        repeat (5) @(negedge clk);
        chk("arst_pre_bclk", bclk, 1);
        chk("arst_pre_sdata", sdata, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bclk", bclk, 0);
        chk("arst_sdata", sdata, 0);
        chk("arst_lrclk", lrclk, 1);
        chk("arst_underrun", underrun, 0);
        chk("arst_ready", data_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        check_frame("after_arst", 32'h0, 1'b1, 1'b0, rf, rp, fa, ra);
        chk("after_arst_fall_edge", fa, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
